// File: rtl/pic_ram_writer_if.sv
// Byte-stream and RAM-write bus of the picture RAM writer.
// The master side supplies frame control and source bytes; the slave
// side (the writer) returns flow control, the RAM write port and status.
interface pic_ram_writer_if #(
  parameter int AW = 19
);
  logic          start;
  logic          abort;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_data;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, byte_in, byte_valid,
    input  byte_ready, ram_we, ram_addr, ram_data, busy, done
  );

  modport slave (
    input  start, abort, byte_in, byte_valid,
    output byte_ready, ram_we, ram_addr, ram_data, busy, done
  );
endinterface

// File: rtl/pic_ram_writer.sv
// Picture RAM writer: assembles RGB565 pixels from a byte stream (high byte
// first) and writes one frame of L x W pixels into RAM in row-major order.
// Each pixel takes HI (high byte), LO (low byte) and WR (write strobe), so a
// pixel costs at least three cycles. abort cancels a frame from any busy state.
module pic_ram_writer #(
  parameter logic [10:0] L  = 11'd640,
  parameter logic [10:0] W  = 11'd480,
  parameter int          AW = 19
) (
  input  logic            clk_vga,
  input  logic            rst,
  pic_ram_writer_if.slave bus
);

  // Index of the last pixel of a frame; L*W must fit in AW address bits.
  localparam int unsigned   PIXELS = int'(L) * int'(W);
  localparam logic [AW-1:0] LAST   = AW'(PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WR,
    FIN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_nxt;
  logic [7:0]    hi_byte;
  logic [AW-1:0] addr_q;
  logic [15:0]   data_q;
  logic          ready;
  logic          we;
  logic          done;
  logic          accept;

  // State register and pixel counter.
  always_ff @(posedge clk_vga or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, regardless of block order.
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter and strobe decode; abort overrides everything while busy.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    we        = 1'b0;
    done      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nxt = HI;
          cnt_nxt   = '0;
        end
      end
      HI: begin
        ready = 1'b1;
        if (bus.byte_valid) state_nxt = LO;
      end
      LO: begin
        ready = 1'b1;
        if (bus.byte_valid) state_nxt = WR;
      end
      WR: begin
        we = 1'b1;
        if (cnt == LAST) begin
          state_nxt = FIN;
        end else begin
          cnt_nxt   = cnt + AW'(1);
          state_nxt = HI;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // A cancelled frame must not consume a byte, write, or signal completion.
    if (bus.abort && (state != IDLE)) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      ready     = 1'b0;
      we        = 1'b0;
      done      = 1'b0;
    end
  end

  assign accept = ready & bus.byte_valid;

  // Byte capture: the high byte waits in hi_byte; the low byte completes the
  // pixel and loads the write address/data, which then hold until the next pixel.
  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      hi_byte <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (accept) begin
      if (state == HI) begin
        hi_byte <= bus.byte_in;
      end else begin
        addr_q <= cnt;
        data_q <= {hi_byte, bus.byte_in};
      end
    end
  end

  assign bus.byte_ready = ready;
  assign bus.ram_we     = we;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_data   = data_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done;

endmodule

// File: tb/tb_pic_ram_writer.sv
// Bench for pic_ram_writer on a 4 x 2 frame. A monitor logs every write,
// done pulse and accepted byte; each test compares those logs against what
// the frame rules predict from the random source bytes that were offered.
module tb_pic_ram_writer;

  localparam logic [10:0] L      = 11'd4;
  localparam logic [10:0] W      = 11'd2;
  localparam int          AW     = 3;
  localparam int          NPIX   = 8;
  localparam int          NBYTES = 16;

  logic clk_vga = 1'b0;
  logic rst     = 1'b0;

  always #5 clk_vga = ~clk_vga;

  pic_ram_writer_if #(.AW(AW)) bus ();

  pic_ram_writer #(.L(L), .W(W), .AW(AW)) dut (
    .clk_vga (clk_vga),
    .rst     (rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0]    src [NBYTES];
  logic [AW-1:0] wr_addr [$];
  logic [15:0]   wr_data [$];
  int            wr_cyc [$];
  int            done_cyc [$];
  logic [7:0]    acc_byte [$];
  int            acc_cyc [$];
  int            ready_in_wr;

  // Cycle stamp shared by the monitor.
  always @(posedge clk_vga) cyc <= cyc + 1;

  // Monitor: log observable events mid-cycle, away from the active edge.
  always @(negedge clk_vga) begin
    if (rst) begin
      if (bus.ram_we) begin
        wr_addr.push_back(bus.ram_addr);
        wr_data.push_back(bus.ram_data);
        wr_cyc.push_back(cyc);
        if (bus.byte_ready) ready_in_wr++;
      end
      if (bus.done) done_cyc.push_back(cyc);
      if (bus.byte_valid && bus.byte_ready) begin
        acc_byte.push_back(bus.byte_in);
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
    acc_byte.delete();
    acc_cyc.delete();
    ready_in_wr = 0;
  endtask

  task automatic fill_src();
    for (int i = 0; i < NBYTES; i++) src[i] = 8'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk_vga);
    #1;
  endtask

  // Start a frame and feed source bytes until done, or until stop_wrs writes
  // or stop_accs accepted bytes have been seen (0 disables a stop), bounded.
  task automatic run_frame(input bit toggle, input int restart_at,
                           input int stop_wrs, input int stop_accs);
    int idx;
    idx = 0;
    clear_logs();
    @(posedge clk_vga); #1;
    bus.start = 1'b1;
    @(posedge clk_vga); #1;
    bus.start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      bus.byte_in    = (idx < NBYTES) ? src[idx] : 8'h00;
      bus.byte_valid = toggle ? ~n[0] : 1'b1;
      bus.start      = (n == restart_at);
      @(negedge clk_vga); #1;
      if (bus.byte_valid && bus.byte_ready) idx++;
      if (done_cyc.size() > 0) break;
      if (stop_wrs > 0 && wr_addr.size() >= stop_wrs) break;
      if (stop_accs > 0 && acc_byte.size() >= stop_accs) break;
      @(posedge clk_vga); #1;
    end
    bus.byte_valid = 1'b0;
    bus.start      = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.byte_ready); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.ram_we); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.ram_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", bus.ram_addr); end
    checks++; if (bus.ram_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.ram_data); end
    @(negedge clk_vga);
    rst = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_normal_frame();
    fill_src();
    src[0] = 8'hF8;
    src[1] = 8'h1F;
    run_frame(1'b0, -1, 0, 0);
    checks++; if (wr_addr.size() !== NPIX) begin errors++; $display("FAIL normal_count: got %0d expected %0d", wr_addr.size(), NPIX); end
    checks++; if (wr_data.size() < 1 || wr_data[0] !== 16'hF81F) begin errors++; $display("FAIL normal_first_pixel: got %0h expected f81f", (wr_data.size() > 0) ? wr_data[0] : 16'hxxxx); end
    for (int i = 0; i < wr_addr.size() && i < NPIX; i++) begin
      checks++;
      if (wr_addr[i] !== i[AW-1:0] || wr_data[i] !== {src[2*i], src[2*i+1]}) begin
        errors++;
        $display("FAIL normal_write%0d: got %0h/%0h expected %0h/%0h", i, wr_addr[i], wr_data[i], i[AW-1:0], {src[2*i], src[2*i+1]});
      end
      if (2*i+1 < acc_cyc.size()) begin
        checks++;
        if (wr_cyc[i] !== acc_cyc[2*i+1] + 1) begin errors++; $display("FAIL normal_latency%0d: got cycle %0d expected %0d", i, wr_cyc[i], acc_cyc[2*i+1] + 1); end
      end
      if (i > 0) begin
        checks++;
        if (wr_cyc[i] - wr_cyc[i-1] !== 3) begin errors++; $display("FAIL normal_spacing%0d: got %0d expected 3", i, wr_cyc[i] - wr_cyc[i-1]); end
      end
    end
    checks++; if (done_cyc.size() !== 1) begin errors++; $display("FAIL normal_done_count: got %0d expected 1", done_cyc.size()); end
    if (done_cyc.size() > 0 && wr_cyc.size() > 0) begin
      checks++;
      if (done_cyc[0] !== wr_cyc[wr_cyc.size()-1] + 1) begin errors++; $display("FAIL normal_done_time: got cycle %0d expected %0d", done_cyc[0], wr_cyc[wr_cyc.size()-1] + 1); end
    end
    idle_cycles(2);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL normal_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_backpressure();
    fill_src();
    run_frame(1'b1, -1, 0, 0);
    checks++; if (wr_addr.size() !== NPIX) begin errors++; $display("FAIL bp_count: got %0d expected %0d", wr_addr.size(), NPIX); end
    for (int i = 0; i < wr_addr.size() && i < NPIX; i++) begin
      checks++;
      if (wr_addr[i] !== i[AW-1:0] || wr_data[i] !== {src[2*i], src[2*i+1]}) begin
        errors++;
        $display("FAIL bp_write%0d: got %0h/%0h expected %0h/%0h", i, wr_addr[i], wr_data[i], i[AW-1:0], {src[2*i], src[2*i+1]});
      end
    end
    checks++; if (ready_in_wr !== 0) begin errors++; $display("FAIL bp_ready_in_wr: got %0d expected 0", ready_in_wr); end
    checks++; if (acc_byte.size() !== NBYTES) begin errors++; $display("FAIL bp_accepted: got %0d expected %0d", acc_byte.size(), NBYTES); end
    for (int i = 0; i < acc_byte.size() && i < NBYTES; i++) begin
      checks++;
      if (acc_byte[i] !== src[i]) begin errors++; $display("FAIL bp_byte%0d: got %0h expected %0h", i, acc_byte[i], src[i]); end
    end
    checks++; if (done_cyc.size() !== 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", done_cyc.size()); end
    idle_cycles(2);
  endtask

  task automatic test_abort();
    int accs;
    fill_src();
    run_frame(1'b0, -1, 3, 0);
    accs = acc_byte.size();
    @(posedge clk_vga); #1;
    bus.abort      = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_in    = src[6];
    @(negedge clk_vga); #1;
    checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", bus.byte_ready); end
    @(posedge clk_vga); #1;
    bus.abort      = 1'b0;
    bus.byte_valid = 1'b1;
    @(negedge clk_vga); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    bus.byte_valid = 1'b0;
    idle_cycles(20);
    checks++; if (wr_addr.size() !== 3) begin errors++; $display("FAIL abort_writes: got %0d expected 3", wr_addr.size()); end
    checks++; if (done_cyc.size() !== 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", done_cyc.size()); end
    checks++; if (acc_byte.size() !== accs) begin errors++; $display("FAIL abort_consumed: got %0d expected %0d", acc_byte.size(), accs); end
    fill_src();
    run_frame(1'b0, -1, 0, 0);
    checks++; if (wr_addr.size() !== NPIX) begin errors++; $display("FAIL abort_next_count: got %0d expected %0d", wr_addr.size(), NPIX); end
    for (int i = 0; i < wr_addr.size() && i < NPIX; i++) begin
      checks++;
      if (wr_addr[i] !== i[AW-1:0] || wr_data[i] !== {src[2*i], src[2*i+1]}) begin
        errors++;
        $display("FAIL abort_next_write%0d: got %0h/%0h expected %0h/%0h", i, wr_addr[i], wr_data[i], i[AW-1:0], {src[2*i], src[2*i+1]});
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_start_while_busy();
    fill_src();
    run_frame(1'b0, 5, 0, 0);
    idle_cycles(6);
    checks++; if (wr_addr.size() !== NPIX) begin errors++; $display("FAIL restart_count: got %0d expected %0d", wr_addr.size(), NPIX); end
    for (int i = 0; i < wr_addr.size() && i < NPIX; i++) begin
      checks++;
      if (wr_addr[i] !== i[AW-1:0]) begin errors++; $display("FAIL restart_addr%0d: got %0h expected %0h", i, wr_addr[i], i[AW-1:0]); end
    end
    checks++; if (done_cyc.size() !== 1) begin errors++; $display("FAIL restart_done_count: got %0d expected 1", done_cyc.size()); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL restart_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_async_reset();
    fill_src();
    src[8] = 8'hA5;
    // Stop once the high byte of pixel 5 (byte 10) has been accepted.
    run_frame(1'b0, -1, 0, 11);
    @(posedge clk_vga); #2;
    bus.byte_valid = 1'b1;
    bus.byte_in    = src[11];
    rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL areset_ready: got %b expected 0", bus.byte_ready); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL areset_we: got %b expected 0", bus.ram_we); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL areset_done: got %b expected 0", bus.done); end
    checks++; if (bus.ram_addr !== '0) begin errors++; $display("FAIL areset_addr: got %0h expected 0", bus.ram_addr); end
    checks++; if (bus.ram_data !== 16'h0) begin errors++; $display("FAIL areset_data: got %0h expected 0", bus.ram_data); end
    bus.byte_valid = 1'b0;
    repeat (2) @(posedge clk_vga);
    @(negedge clk_vga);
    rst = 1'b1;
    idle_cycles(2);
    fill_src();
    run_frame(1'b0, -1, 0, 0);
    checks++; if (wr_addr.size() !== NPIX) begin errors++; $display("FAIL areset_next_count: got %0d expected %0d", wr_addr.size(), NPIX); end
    for (int i = 0; i < wr_addr.size() && i < NPIX; i++) begin
      checks++;
      if (wr_addr[i] !== i[AW-1:0] || wr_data[i] !== {src[2*i], src[2*i+1]}) begin
        errors++;
        $display("FAIL areset_next_write%0d: got %0h/%0h expected %0h/%0h", i, wr_addr[i], wr_data[i], i[AW-1:0], {src[2*i], src[2*i+1]});
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_start_abort_idle();
    clear_logs();
    @(posedge clk_vga); #1;
    bus.start      = 1'b1;
    bus.abort      = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h5A;
    @(posedge clk_vga); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_vga); #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL sa_busy%0d: got %b expected 0", n, bus.busy); end
      checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL sa_ready%0d: got %b expected 0", n, bus.byte_ready); end
    end
    bus.byte_valid = 1'b0;
    checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL sa_writes: got %0d expected 0", wr_addr.size()); end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    ready_in_wr    = 0;
    test_reset();
    test_normal_frame();
    test_backpressure();
    test_abort();
    test_start_while_busy();
    test_async_reset();
    test_start_abort_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
